melody_request_arbiter: RTL and testbench

- Shares one melody player between REQUESTERS independent sources (UI buttons, alarms, status events).
- Latches one pending request per source with its melody ID and grants the player round-robin.
- Drives the player's play/stop/select inputs and watches its busy flag.
- Sits between the request sources and the melody player in the top level.

---
 rtl/melody_request_arbiter_pkg.sv | 30 +++
 rtl/melody_request_arbiter_rr_priority_picker.sv | 46 ++++
 rtl/melody_request_arbiter.sv | 169 ++++++++++++++++
 tb/tb_melody_request_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/melody_request_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : melody_request_arbiter_pkg
// Description : Shared FSM encoding and one-hot helper for the melody arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package melody_request_arbiter_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_WAIT_BUSY = 3'd2,
        ST_PLAYING   = 3'd3,
        ST_GAP       = 3'd4
    } arb_state_t;

    // Index of the set bit in a one-hot vector of up to eight sources.
    function automatic logic [2:0] onehot_to_index(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = '0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/melody_request_arbiter_rr_priority_picker.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_picker
// Description : Round-robin pick of the first pending bit at or above pointer.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_picker
    import melody_request_arbiter_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int PTR_W      = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
    input  logic [REQUESTERS-1:0] i_pending,
    input  logic [PTR_W-1:0]      i_pointer,
    output logic [REQUESTERS-1:0] o_grant,
    output logic [PTR_W-1:0]      o_index,
    output logic                  o_valid
);

    logic [REQUESTERS-1:0] w_hi;
    logic [REQUESTERS-1:0] w_lo;
    logic [REQUESTERS-1:0] w_grant;

    // w_hi searches from the pointer upward, w_lo supplies the wrap-around.
    always_comb begin
        w_hi = '0;
        w_lo = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (i_pending[i] && (PTR_W'(i) >= i_pointer) && (w_hi == '0)) begin
                w_hi[i] = 1'b1;
            end
        end
        for (int i = 0; i < REQUESTERS; i++) begin
            if (i_pending[i] && (w_lo == '0)) begin
                w_lo[i] = 1'b1;
            end
        end
        w_grant = (w_hi != '0) ? w_hi : w_lo;
    end

    assign o_grant = w_grant;
    assign o_index = PTR_W'(onehot_to_index(8'(w_grant)));
    assign o_valid = |i_pending;

endmodule
`default_nettype wire

// File: rtl/melody_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : melody_request_arbiter
// Description : Latches per-source melody requests and shares one player RR.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_request_arbiter
    import melody_request_arbiter_pkg::*;
#(
    parameter int REQUESTERS    = 4,
    parameter int ID_WIDTH      = 3,
    parameter int GAP_CYCLES    = 1000,
    parameter int START_TIMEOUT = 16
) (
    input  logic                           Clock,
    input  logic                           Reset,
    input  logic [REQUESTERS-1:0]          Request_i,
    input  logic [REQUESTERS*ID_WIDTH-1:0] MelodyId_i,
    input  logic                           Cancel_i,
    output logic                           PlayerPlay_o,
    output logic                           PlayerStop_o,
    output logic [ID_WIDTH-1:0]            PlayerMelody_o,
    input  logic                           PlayerBusy_i,
    output logic [REQUESTERS-1:0]          Grant_o,
    output logic [REQUESTERS-1:0]          Pending_o,
    output logic [REQUESTERS-1:0]          Done_o,
    output logic                           Aborted_o
);

    localparam int c_PTR_W   = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
    localparam int c_CNT_MAX = (GAP_CYCLES > START_TIMEOUT) ? GAP_CYCLES : START_TIMEOUT;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST     = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_TIMEOUT_LAST = c_CNT_W'(START_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT      = c_CNT_W'(c_CNT_MAX);
    localparam logic [c_PTR_W-1:0] c_LAST_IDX     = c_PTR_W'(REQUESTERS - 1);

    arb_state_t            r_state;
    logic [REQUESTERS-1:0] r_pending;
    logic [ID_WIDTH-1:0]   r_ids [REQUESTERS];
    logic [c_PTR_W-1:0]    r_ptr;
    logic [c_PTR_W-1:0]    r_idx;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [REQUESTERS-1:0] r_grant;
    logic [ID_WIDTH-1:0]   r_melody;
    logic                  r_play;
    logic                  r_stop;
    logic [REQUESTERS-1:0] r_done;
    logic                  r_aborted;

    logic [REQUESTERS-1:0] w_pick;
    logic [c_PTR_W-1:0]    w_pick_idx;
    logic                  w_pick_valid;
    logic [REQUESTERS-1:0] w_clear;
    logic [REQUESTERS-1:0] w_accept;
    logic                  w_active;
    logic                  w_cancel;
    logic                  w_timeout;
    logic                  w_finish;
    logic                  w_end;
    logic [c_PTR_W-1:0]    w_ptr_next;

    rr_priority_picker #(
        .REQUESTERS (REQUESTERS),
        .PTR_W      (c_PTR_W)
    ) u_picker (
        .i_pending (r_pending),
        .i_pointer (r_ptr),
        .o_grant   (w_pick),
        .o_index   (w_pick_idx),
        .o_valid   (w_pick_valid)
    );

    // A request coinciding with its own grant re-arms the bit with the new ID.
    assign w_clear  = ((r_state == ST_IDLE) && w_pick_valid) ? w_pick : '0;
    assign w_accept = Request_i & (~r_pending | w_clear);

    assign w_active   = (r_state == ST_START) || (r_state == ST_WAIT_BUSY) || (r_state == ST_PLAYING);
    assign w_cancel   = w_active && Cancel_i;
    assign w_timeout  = !Cancel_i && (r_state == ST_WAIT_BUSY) && !PlayerBusy_i && (r_cnt >= c_TIMEOUT_LAST);
    assign w_finish   = !Cancel_i && (r_state == ST_PLAYING) && !PlayerBusy_i;
    assign w_end      = w_cancel || w_timeout || w_finish;
    assign w_ptr_next = (r_idx == c_LAST_IDX) ? '0 : r_idx + 1'b1;

    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_id_latch
        always_ff @(posedge Clock or negedge Reset) begin
            if (!Reset) begin
                r_ids[gi] <= '0;
            end else if (w_accept[gi]) begin
                r_ids[gi] <= MelodyId_i[gi*ID_WIDTH +: ID_WIDTH];
            end
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_ptr     <= '0;
            r_idx     <= '0;
            r_cnt     <= '0;
            r_grant   <= '0;
            r_melody  <= '0;
            r_play    <= 1'b0;
            r_stop    <= 1'b0;
            r_done    <= '0;
            r_aborted <= 1'b0;
        end else begin
            r_play    <= 1'b0;
            r_stop    <= 1'b0;
            r_done    <= '0;
            r_aborted <= 1'b0;
            r_pending <= (r_pending & ~w_clear) | w_accept;
            if (w_end) begin
                r_state   <= ST_GAP;
                r_cnt     <= '0;
                r_grant   <= '0;
                r_done    <= r_grant;
                r_aborted <= w_cancel || w_timeout;
                r_stop    <= w_cancel;
                r_ptr     <= w_ptr_next;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_pick_valid) begin
                            r_grant  <= w_pick;
                            r_idx    <= w_pick_idx;
                            r_melody <= r_ids[w_pick_idx];
                            r_play   <= 1'b1;
                            r_state  <= ST_START;
                        end
                    end
                    ST_START: begin
                        r_cnt   <= '0;
                        r_state <= ST_WAIT_BUSY;
                    end
                    ST_WAIT_BUSY: begin
                        if (PlayerBusy_i) begin
                            r_state <= ST_PLAYING;
                        end else if (r_cnt != c_CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    ST_PLAYING: begin
                        r_state <= ST_PLAYING;
                    end
                    ST_GAP: begin
                        if (r_cnt >= c_GAP_LAST) begin
                            r_state <= ST_IDLE;
                        end else if (r_cnt != c_CNT_SAT) begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign PlayerPlay_o   = r_play;
    assign PlayerStop_o   = r_stop;
    assign PlayerMelody_o = r_melody;
    assign Grant_o        = r_grant;
    assign Pending_o      = r_pending;
    assign Done_o         = r_done;
    assign Aborted_o      = r_aborted;

endmodule
`default_nettype wire

// File: tb/tb_melody_request_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_request_arbiter
// Description : Directed table-driven bench for melody_request_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_request_arbiter;

    localparam int N = 4;
    localparam int W = 3;

    logic           Clock = 1'b0;
    logic           Reset = 1'b0;
    logic [N-1:0]   Request_i = '0;
    logic [N*W-1:0] MelodyId_i = '0;
    logic           Cancel_i = 1'b0;
    logic           PlayerBusy_i = 1'b0;
    logic           PlayerPlay_o;
    logic           PlayerStop_o;
    logic [W-1:0]   PlayerMelody_o;
    logic [N-1:0]   Grant_o;
    logic [N-1:0]   Pending_o;
    logic [N-1:0]   Done_o;
    logic           Aborted_o;

    melody_request_arbiter #(
        .REQUESTERS    (N),
        .ID_WIDTH      (W),
        .GAP_CYCLES    (1000),
        .START_TIMEOUT (16)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Request_i      (Request_i),
        .MelodyId_i     (MelodyId_i),
        .Cancel_i       (Cancel_i),
        .PlayerPlay_o   (PlayerPlay_o),
        .PlayerStop_o   (PlayerStop_o),
        .PlayerMelody_o (PlayerMelody_o),
        .PlayerBusy_i   (PlayerBusy_i),
        .Grant_o        (Grant_o),
        .Pending_o      (Pending_o),
        .Done_o         (Done_o),
        .Aborted_o      (Aborted_o)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [N-1:0]   req;
        logic [N*W-1:0] ids;
        int             mode;      // 0 normal end, 1 cancel, 2 start timeout
        logic [N-1:0]   exp_grant;
        logic [W-1:0]   exp_mel;
        int             exp_lat;   // ticks from request return to play, <0 = unchecked
    } vec_t;

    vec_t vecs[4];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge Clock);
    endtask

    task automatic request(input logic [N-1:0] req, input logic [N*W-1:0] ids);
        Request_i  = req;
        MelodyId_i = ids;
        tick();
        Request_i  = '0;
        MelodyId_i = '0;
    endtask

    task automatic wait_play(input int max, output int cycles);
        cycles = 0;
        while (!PlayerPlay_o && cycles < max) begin
            tick();
            cycles++;
        end
        if (!PlayerPlay_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL play_wait: no play pulse within %0d cycles", max);
        end
    endtask

    task automatic wait_done(input int max, output int cycles);
        cycles = 0;
        do begin
            tick();
            cycles++;
        end while (Done_o == '0 && cycles < max);
        if (Done_o == '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL done_wait: no done pulse within %0d cycles", max);
        end
    endtask

    // Busy must already have been high for at least two edges.
    task automatic end_normal(input logic [N-1:0] exp_grant, input string name);
        int c;
        PlayerBusy_i = 1'b0;
        wait_done(8, c);
        check({name, "_done"}, Done_o, exp_grant);
        check({name, "_aborted"}, Aborted_o, 0);
        check({name, "_done_lat"}, c, 1);
        check({name, "_grant_clr"}, Grant_o, 0);
    endtask

    task automatic run_vec(input vec_t v, input int k);
        int lat;
        int c;
        string nm;
        nm = $sformatf("vec%0d", k);
        request(v.req, v.ids);
        wait_play(1200, lat);
        if (v.exp_lat >= 0) check({nm, "_play_lat"}, lat, v.exp_lat);
        check({nm, "_grant"}, Grant_o, v.exp_grant);
        check({nm, "_melody"}, PlayerMelody_o, v.exp_mel);
        case (v.mode)
            0: begin
                PlayerBusy_i = 1'b1;
                tick();
                check({nm, "_play_single"}, PlayerPlay_o, 0);
                repeat (9) tick();
                end_normal(v.exp_grant, nm);
            end
            1: begin
                PlayerBusy_i = 1'b1;
                tick();
                check({nm, "_play_single"}, PlayerPlay_o, 0);
                repeat (4) tick();
                Cancel_i = 1'b1;
                tick();
                Cancel_i = 1'b0;
                check({nm, "_stop"}, PlayerStop_o, 1);
                check({nm, "_cancel_done"}, Done_o, v.exp_grant);
                check({nm, "_cancel_aborted"}, Aborted_o, 1);
                check({nm, "_cancel_grant_clr"}, Grant_o, 0);
                PlayerBusy_i = 1'b0;
                tick();
                check({nm, "_stop_single"}, PlayerStop_o, 0);
                check({nm, "_done_single"}, Done_o, 0);
            end
            default: begin
                wait_done(40, c);
                check({nm, "_timeout_lat"}, c, 17);
                check({nm, "_timeout_done"}, Done_o, v.exp_grant);
                check({nm, "_timeout_aborted"}, Aborted_o, 1);
                check({nm, "_timeout_nostop"}, PlayerStop_o, 0);
            end
        endcase
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat;

        vecs[0] = '{4'b0100, {3'd0, 3'd5, 3'd0, 3'd0}, 0, 4'b0100, 3'd5, 1};
        vecs[1] = '{4'b0100, {3'd0, 3'd7, 3'd0, 3'd0}, 1, 4'b0100, 3'd7, -1};
        vecs[2] = '{4'b0010, {3'd0, 3'd0, 3'd2, 3'd0}, 2, 4'b0010, 3'd2, -1};
        vecs[3] = '{4'b1000, {3'd6, 3'd0, 3'd0, 3'd0}, 0, 4'b1000, 3'd6, -1};

        Reset = 1'b0;
        repeat (9) tick();
        check("rst_grant", Grant_o, 0);
        check("rst_pending", Pending_o, 0);
        check("rst_play", PlayerPlay_o, 0);
        check("rst_melody", PlayerMelody_o, 0);
        check("rst_done", {Done_o, Aborted_o, PlayerStop_o}, 0);
        Reset = 1'b1;

        for (int k = 0; k < 4; k++) begin
            run_vec(vecs[k], k);
        end

        // Pointer is now 0: simultaneous 0,1,3 served in order, plus re-request and duplicate.
        request(4'b1011, {3'd4, 3'd0, 3'd2, 3'd1});
        check("multi_pending", Pending_o, 4'b1011);
        wait_play(1200, lat);
        check("gap_cycles", lat, 1000);
        check("multi0_grant", Grant_o, 4'b0001);
        check("multi0_melody", PlayerMelody_o, 1);
        check("multi0_pending", Pending_o, 4'b1010);
        PlayerBusy_i = 1'b1;
        tick();
        request(4'b0001, {3'd0, 3'd0, 3'd0, 3'd3});
        check("rerequest_pending", Pending_o, 4'b1011);
        end_normal(4'b0001, "multi0");

        wait_play(1200, lat);
        check("multi1_grant", Grant_o, 4'b0010);
        check("multi1_melody", PlayerMelody_o, 2);
        PlayerBusy_i = 1'b1;
        repeat (3) tick();
        end_normal(4'b0010, "multi1");

        wait_play(1200, lat);
        check("multi3_grant", Grant_o, 4'b1000);
        check("multi3_melody", PlayerMelody_o, 4);
        PlayerBusy_i = 1'b1;
        request(4'b0010, {3'd0, 3'd0, 3'd3, 3'd0});
        request(4'b0010, {3'd0, 3'd0, 3'd6, 3'd0});
        check("dup_pending", Pending_o, 4'b0011);
        end_normal(4'b1000, "multi3");

        wait_play(1200, lat);
        check("reserve0_grant", Grant_o, 4'b0001);
        check("reserve0_melody", PlayerMelody_o, 3);
        PlayerBusy_i = 1'b1;
        repeat (3) tick();
        end_normal(4'b0001, "reserve0");

        wait_play(1200, lat);
        check("dup_grant", Grant_o, 4'b0010);
        check("dup_melody", PlayerMelody_o, 3);
        PlayerBusy_i = 1'b1;
        repeat (3) tick();
        end_normal(4'b0010, "dup");

        // Asynchronous reset in the middle of a melody (pointer is 2 here).
        request(4'b0100, {3'd0, 3'd5, 3'd0, 3'd0});
        wait_play(1200, lat);
        check("rstmid_grant_before", Grant_o, 4'b0100);
        PlayerBusy_i = 1'b1;
        request(4'b0001, {3'd0, 3'd0, 3'd0, 3'd1});
        repeat (2) tick();
        #2;
        Reset = 1'b0;
        #1;
        check("rstmid_grant", Grant_o, 0);
        check("rstmid_pending", Pending_o, 0);
        check("rstmid_play", PlayerPlay_o, 0);
        check("rstmid_stop", PlayerStop_o, 0);
        check("rstmid_melody", PlayerMelody_o, 0);
        PlayerBusy_i = 1'b0;
        tick();
        tick();
        Reset = 1'b1;
        request(4'b1001, {3'd2, 3'd0, 3'd0, 3'd4});
        wait_play(4, lat);
        check("post_rst_lat", lat, 1);
        check("post_rst_grant", Grant_o, 4'b0001);
        check("post_rst_melody", PlayerMelody_o, 4);
        PlayerBusy_i = 1'b1;
        repeat (3) tick();
        end_normal(4'b0001, "post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
